// File: rtl/tri_setup_if.sv
// Vertex capture handshake and setup result bundle between the vertex stage
// and the rasterizer; signal names match the original flat port list.
interface tri_setup_if;
  logic               start;
  logic        [9:0]  ax, ay, bx, by, cx, cy;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic        [9:0]  min_x, max_x, min_y, max_y;
  logic signed [10:0] e0_a, e0_b, e1_a, e1_b, e2_a, e2_b;
  logic signed [20:0] e0_c, e1_c, e2_c;
  logic signed [22:0] area;
  logic               degenerate;

  modport master (
    output start, ax, ay, bx, by, cx, cy, out_ready,
    input  busy, out_valid, min_x, max_x, min_y, max_y,
           e0_a, e0_b, e1_a, e1_b, e2_a, e2_b, e0_c, e1_c, e2_c, area, degenerate
  );

  modport slave (
    input  start, ax, ay, bx, by, cx, cy, out_ready,
    output busy, out_valid, min_x, max_x, min_y, max_y,
           e0_a, e0_b, e1_a, e1_b, e2_a, e2_b, e0_c, e1_c, e2_c, area, degenerate
  );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: clamped bounding box, edge equation coefficients and doubled
// signed area, using a single shared 10x10 multiplier over six cycles.
module tri_setup (
  input  logic     clk_pix,
  input  logic     rst,
  tri_setup_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BBOX,
    S_MUL,
    S_AREA,
    S_VALID
  } state_t;

  localparam logic [9:0] X_LIMIT = 10'd639;
  localparam logic [9:0] Y_LIMIT = 10'd479;

  state_t             state;
  logic [2:0]         cnt;
  logic [9:0]         ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic [19:0]        prod_hold;
  logic [9:0]         mul_a, mul_b;
  logic [19:0]        prod;
  logic signed [20:0] c_diff;
  logic signed [22:0] area_sum;

  function automatic logic [9:0] min3(input logic [9:0] p, q, r);
    logic [9:0] m;
    m = (p < q) ? p : q;
    return (m < r) ? m : r;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] p, q, r);
    logic [9:0] m;
    m = (p > q) ? p : q;
    return (m > r) ? m : r;
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic signed [10:0] sdiff(input logic [9:0] p, input logic [9:0] q);
    return $signed({1'b0, p}) - $signed({1'b0, q});
  endfunction

  // Even counts fetch the first product of a pair, odd counts the second.
  always_comb begin
    mul_a = ax_r;
    mul_b = cy_r;
    case (cnt)
      3'd0:    begin mul_a = ax_r; mul_b = by_r; end
      3'd1:    begin mul_a = bx_r; mul_b = ay_r; end
      3'd2:    begin mul_a = bx_r; mul_b = cy_r; end
      3'd3:    begin mul_a = cx_r; mul_b = by_r; end
      3'd4:    begin mul_a = cx_r; mul_b = ay_r; end
      default: begin mul_a = ax_r; mul_b = cy_r; end
    endcase
  end

  assign prod     = {10'd0, mul_a} * {10'd0, mul_b};
  assign c_diff   = $signed({1'b0, prod_hold}) - $signed({1'b0, prod});
  assign area_sum = {{2{bus.e0_c[20]}}, bus.e0_c}
                  + {{2{bus.e1_c[20]}}, bus.e1_c}
                  + {{2{bus.e2_c[20]}}, bus.e2_c};

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      ax_r           <= '0;
      ay_r           <= '0;
      bx_r           <= '0;
      by_r           <= '0;
      cx_r           <= '0;
      cy_r           <= '0;
      prod_hold      <= '0;
      bus.busy       <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.min_x      <= '0;
      bus.max_x      <= '0;
      bus.min_y      <= '0;
      bus.max_y      <= '0;
      bus.e0_a       <= '0;
      bus.e0_b       <= '0;
      bus.e1_a       <= '0;
      bus.e1_b       <= '0;
      bus.e2_a       <= '0;
      bus.e2_b       <= '0;
      bus.e0_c       <= '0;
      bus.e1_c       <= '0;
      bus.e2_c       <= '0;
      bus.area       <= '0;
      bus.degenerate <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // The capture edge doubles as the CAPTURE step, keeping VALID at +8.
          if (bus.start) begin
            ax_r     <= bus.ax;
            ay_r     <= bus.ay;
            bx_r     <= bus.bx;
            by_r     <= bus.by;
            cx_r     <= bus.cx;
            cy_r     <= bus.cy;
            bus.busy <= 1'b1;
            state    <= S_BBOX;
          end
        end
        S_BBOX: begin
          bus.min_x <= clamp(min3(ax_r, bx_r, cx_r), X_LIMIT);
          bus.max_x <= clamp(max3(ax_r, bx_r, cx_r), X_LIMIT);
          bus.min_y <= clamp(min3(ay_r, by_r, cy_r), Y_LIMIT);
          bus.max_y <= clamp(max3(ay_r, by_r, cy_r), Y_LIMIT);
          bus.e0_a  <= sdiff(ay_r, by_r);
          bus.e0_b  <= sdiff(bx_r, ax_r);
          bus.e1_a  <= sdiff(by_r, cy_r);
          bus.e1_b  <= sdiff(cx_r, bx_r);
          bus.e2_a  <= sdiff(cy_r, ay_r);
          bus.e2_b  <= sdiff(ax_r, cx_r);
          cnt       <= '0;
          state     <= S_MUL;
        end
        S_MUL: begin
          case (cnt)
            3'd1:    bus.e0_c  <= c_diff;
            3'd3:    bus.e1_c  <= c_diff;
            3'd5:    bus.e2_c  <= c_diff;
            default: prod_hold <= prod;
          endcase
          if (cnt == 3'd5) begin
            cnt   <= '0;
            state <= S_AREA;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_AREA: begin
          bus.area       <= area_sum;
          bus.degenerate <= (area_sum == '0);
          bus.out_valid  <= 1'b1;
          state          <= S_VALID;
        end
        S_VALID: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          bus.busy      <= 1'b0;
          bus.out_valid <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tri_setup.md
TRI_SETUP -- requirements
Module: tri_setup

Interface
REQ-001 SHALL have port clk_pix, input, 1: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1: request to capture a triangle; sampled only in IDLE.
REQ-004 SHALL have ports ax, ay, bx, by, cx, cy, input, 10 each: unsigned screen-space vertex coordinates from the vertex shader.
REQ-005 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-006 SHALL have port out_valid, output, 1: setup results available.
REQ-007 SHALL have port out_ready, input, 1: the downstream rasterizer accepts the results.
REQ-008 SHALL have ports min_x, max_x, min_y, max_y, output, 10 each: clamped bounding box.
REQ-009 SHALL have ports e0_a, e0_b, e1_a, e1_b, e2_a, e2_b, output, 11 signed each: edge step coefficients.
REQ-010 SHALL have ports e0_c, e1_c, e2_c, output, 21 signed each: edge constants.
REQ-011 SHALL have port area, output, 23 signed: twice the signed triangle area.
REQ-012 SHALL have port degenerate, output, 1: high when area == 0.

Function
REQ-013 SHALL implement the FSM IDLE -> CAPTURE -> BBOX -> MUL (6 cycles, counter 0..5) -> AREA -> VALID -> IDLE.
REQ-014 In IDLE, start=1 SHALL register all six vertex inputs on that edge and enter BBOX; the registered copies are used thereafter, so later input changes have no effect.
REQ-015 start SHALL be ignored and dropped in every state other than IDLE, including VALID.
REQ-016 The BBOX state SHALL compute min/max of the x and y coordinates, clamping x to at most 639 and y to at most 479.
REQ-017 Edge k runs from vertex v_k to v_(k+1) (a->b, b->c, c->a), with A = y_k - y_(k+1), B = x_(k+1) - x_k and C = x_k*y_(k+1) - x_(k+1)*y_k.
REQ-018 The A and B coefficients SHALL be computed as 11-bit signed values.
REQ-019 The C terms SHALL use one shared 10x10 unsigned multiplier, one product per MUL cycle, in the fixed order ax*by, bx*ay, bx*cy, cx*by, cx*ay, ax*cy.
REQ-020 Each C value SHALL be the 21-bit signed difference of its two products.
REQ-021 The AREA state SHALL set area = e0_c + e1_c + e2_c with 23-bit sign extension, and set degenerate = (area == 0).
REQ-022 out_valid SHALL rise exactly 8 clk_pix edges after the edge that sampled start, giving a fixed 9-cycle occupancy to VALID.
REQ-023 In VALID, all result outputs SHALL remain stable until out_ready=1 is sampled; that edge returns the FSM to IDLE and clears out_valid.
REQ-024 Result outputs SHALL hold their last values in IDLE and update only during the next setup, so they are not valid outside out_valid.
REQ-025 Negative area, meaning clockwise winding, SHALL be reported unmodified; culling is the consumer's job.

Reset
REQ-026 rst=1 SHALL force IDLE on the next edge and zero all outputs and internal registers, including the MUL counter, from any state.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.
REQ-028 After rst deasserts, the first start sampled in IDLE SHALL begin a fresh setup.

Verification
REQ-029 Nominal case: a=(320,120), b=(220,240), c=(420,240), start pulse, out_ready=1 -> out_valid at edge +8. Expected results: bbox x 220..420, y 120..240; e0 = (-120, -100, 50400); e1 = (0, 200, -48000); e2 = (120, -100, -26400); area = -24000; degenerate = 0.
REQ-030 Collinear case: a=(0,0), b=(10,10), c=(20,20) -> area = 0 and degenerate = 1.
REQ-031 Clamping case: a=(700,10), b=(5,500), c=(100,20) -> min_x = 5, max_x = 639, min_y = 10, max_y = 479.
REQ-032 Back-pressure case: out_ready held low for 5 cycles in VALID -> all outputs constant; out_ready=1 -> IDLE next edge.
REQ-033 Ignored-start case: start pulses during MUL and during VALID -> no restart and the original results are unchanged; a start after returning to IDLE is accepted.
REQ-034 Reset mid-operation case: rst during MUL cycle 3 -> IDLE with all outputs 0 next edge; a following start with the nominal vertices reproduces the REQ-029 results.
